cmp_tally_window: RTL and testbench



---
 rtl/cmp_tally_window.sv | 145 ++++++++++++++
 tb/tb_cmp_tally_window.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_tally_window.sv
// rtl/cmp_tally_window.sv - windowed tally of one-hot comparator results with majority and error flag
// Optional feature macro: CMP_TALLY_ABORT_EN (adds abort input to cancel a running window)
module cmp_tally_window #(
    parameter int WINDOW = 8,
    parameter int CW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [2:0]    cmp,
`ifdef CMP_TALLY_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt_gt,
    output logic [CW-1:0] cnt_eq,
    output logic [CW-1:0] cnt_lt,
    output logic [2:0]    maj,
    output logic          err
);

    localparam int WCW = $clog2(WINDOW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CW-1:0]  CNT_MAX  = '1;
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW);

    logic [1:0]     state;
    logic [WCW-1:0] win_cnt;

    logic           accept;
    logic           last;
    logic           abort_req;
    logic           is_gt;
    logic           is_eq;
    logic           is_lt;
    logic           onehot;
    logic [CW-1:0]  gt_nxt;
    logic [CW-1:0]  eq_nxt;
    logic [CW-1:0]  lt_nxt;
    logic [2:0]     maj_nxt;

    always_comb begin
        accept = (state == S_RUN) && in_valid;
        last   = accept && ((win_cnt + WCW'(1)) == WIN_LAST);
        is_gt  = (cmp == 3'b100);
        is_eq  = (cmp == 3'b010);
        is_lt  = (cmp == 3'b001);
        onehot = is_gt || is_eq || is_lt;
`ifdef CMP_TALLY_ABORT_EN
        abort_req = (state == S_RUN) && abort;
`else
        abort_req = 1'b0;
`endif
    end

    // Next class counts, saturating; shared by the count update and the majority decision
    always_comb begin
        gt_nxt = cnt_gt;
        eq_nxt = cnt_eq;
        lt_nxt = cnt_lt;
        if (accept && is_gt && (cnt_gt != CNT_MAX)) gt_nxt = cnt_gt + CW'(1);
        if (accept && is_eq && (cnt_eq != CNT_MAX)) eq_nxt = cnt_eq + CW'(1);
        if (accept && is_lt && (cnt_lt != CNT_MAX)) lt_nxt = cnt_lt + CW'(1);
    end

    // Strictly greatest count wins; any tie at the maximum yields no majority
    always_comb begin
        maj_nxt = 3'b000;
        if ((gt_nxt > eq_nxt) && (gt_nxt > lt_nxt)) begin
            maj_nxt = 3'b100;
        end else if ((eq_nxt > gt_nxt) && (eq_nxt > lt_nxt)) begin
            maj_nxt = 3'b010;
        end else if ((lt_nxt > gt_nxt) && (lt_nxt > eq_nxt)) begin
            maj_nxt = 3'b001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            win_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt_gt  <= '0;
            cnt_eq  <= '0;
            cnt_lt  <= '0;
            maj     <= 3'b000;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        win_cnt <= '0;
                        cnt_gt  <= '0;
                        cnt_eq  <= '0;
                        cnt_lt  <= '0;
                        maj     <= 3'b000;
                        err     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort_req) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        win_cnt <= '0;
                        cnt_gt  <= '0;
                        cnt_eq  <= '0;
                        cnt_lt  <= '0;
                        maj     <= 3'b000;
                        err     <= 1'b0;
                    end else if (accept) begin
                        win_cnt <= win_cnt + WCW'(1);
                        cnt_gt  <= gt_nxt;
                        cnt_eq  <= eq_nxt;
                        cnt_lt  <= lt_nxt;
                        if (!onehot) err <= 1'b1;
                        if (last) begin
                            state <= S_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            maj   <= maj_nxt;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_tally_window.sv
// tb/tb_cmp_tally_window.sv - directed scoreboard bench for cmp_tally_window (WINDOW=4 and WINDOW=20)
module tb_cmp_tally_window;

    typedef struct packed {
        logic [3:0] gt;
        logic [3:0] eq;
        logic [3:0] lt;
        logic [2:0] maj;
        logic       err;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start_b;
    logic       in_valid;
    logic [2:0] cmp;
`ifdef CMP_TALLY_ABORT_EN
    logic       abort;
`endif

    logic       busy_a, done_a, err_a;
    logic [3:0] gt_a, eq_a, lt_a;
    logic [2:0] maj_a;
    logic       busy_b, done_b, err_b;
    logic [3:0] gt_b, eq_b, lt_b;
    logic [2:0] maj_b;

    int   n_assert = 0;
    int   n_fail   = 0;
    res_t sb[$];
    res_t exp_r;
    logic [2:0] smp[$];

    always #5 clk = ~clk;

    cmp_tally_window #(.WINDOW(4), .CW(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .cmp(cmp),
`ifdef CMP_TALLY_ABORT_EN
        .abort(abort),
`endif
        .busy(busy_a), .done(done_a), .cnt_gt(gt_a), .cnt_eq(eq_a), .cnt_lt(lt_a),
        .maj(maj_a), .err(err_a)
    );

    cmp_tally_window #(.WINDOW(20), .CW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .cmp(cmp),
`ifdef CMP_TALLY_ABORT_EN
        .abort(1'b0),
`endif
        .busy(busy_b), .done(done_b), .cnt_gt(gt_b), .cnt_eq(eq_b), .cnt_lt(lt_b),
        .maj(maj_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference tally of the samples in smp, saturating at 15
    function automatic res_t model();
        res_t r;
        int g = 0, e = 0, l = 0;
        r = '0;
        foreach (smp[i]) begin
            case (smp[i])
                3'b100:  g = (g < 15) ? g + 1 : 15;
                3'b010:  e = (e < 15) ? e + 1 : 15;
                3'b001:  l = (l < 15) ? l + 1 : 15;
                default: r.err = 1'b1;
            endcase
        end
        r.gt = 4'(g);
        r.eq = 4'(e);
        r.lt = 4'(l);
        if (g > e && g > l)      r.maj = 3'b100;
        else if (e > g && e > l) r.maj = 3'b010;
        else if (l > g && l > e) r.maj = 3'b001;
        else                     r.maj = 3'b000;
        return r;
    endfunction

    task automatic check_result_a(input string tag);
        exp_r = sb.pop_front();
        chk({tag, "_gt"},  32'(gt_a),  32'(exp_r.gt));
        chk({tag, "_eq"},  32'(eq_a),  32'(exp_r.eq));
        chk({tag, "_lt"},  32'(lt_a),  32'(exp_r.lt));
        chk({tag, "_maj"}, 32'(maj_a), 32'(exp_r.maj));
        chk({tag, "_err"}, 32'(err_a), 32'(exp_r.err));
    endtask

    // Runs one WINDOW=4 window on dut_a: gap idle cycles before each sample,
    // optional start pulse alongside sample start_at, and start held through FIN if fin_start
    task automatic run_a(input string tag, input int gap, input int start_at, input bit fin_start);
        sb.push_back(model());
        start = 1'b1;
        in_valid = 1'b1;
        cmp = 3'b100;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_busy_run"}, 32'(busy_a), 32'd1);
        chk({tag, "_clr_gt"}, 32'(gt_a), 32'd0);
        foreach (smp[i]) begin
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            cmp = smp[i];
            start = (i == start_at);
            @(negedge clk);
            in_valid = 1'b0;
            start = 1'b0;
            if (i < smp.size() - 1)
                chk({tag, "_early_done"}, 32'(done_a), 32'd0);
        end
        chk({tag, "_done"}, 32'(done_a), 32'd1);
        chk({tag, "_busy_fin"}, 32'(busy_a), 32'd0);
        check_result_a(tag);
        start = fin_start;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(done_a), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy_a), 32'd0);
        sb.push_back(exp_r);
        check_result_a({tag, "_hold"});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start_b = 1'b0;
        in_valid = 1'b0;
        cmp = 3'b000;
`ifdef CMP_TALLY_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_cnts", 32'({gt_a, eq_a, lt_a}), 32'd0);
        chk("rst_maj_err", 32'({maj_a, err_a}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        smp = {3'b001, 3'b001, 3'b001, 3'b001};
        run_a("all_lt", 0, -1, 1'b0);
        smp = {3'b100, 3'b010, 3'b100, 3'b001};
        run_a("gaps", 2, -1, 1'b0);
        smp = {3'b100, 3'b100, 3'b001, 3'b001};
        run_a("tie", 0, -1, 1'b0);
        smp = {3'b100, 3'b011, 3'b001, 3'b100};
        run_a("err", 1, -1, 1'b0);
        // start mid-run and during FIN must not disturb the tally
        smp = {3'b010, 3'b010, 3'b100, 3'b001};
        run_a("start_ign", 0, 2, 1'b1);

        // Async reset mid-window
        smp = {3'b100, 3'b100};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (smp[i]) begin
            in_valid = 1'b1;
            cmp = smp[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_rst_gt", 32'(gt_a), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_out", 32'({done_a, gt_a, eq_a, lt_a, maj_a, err_a}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy_a), 32'd0);

        // WINDOW=20 saturation on dut_b
        smp = {};
        repeat (20) smp.push_back(3'b010);
        sb.push_back(model());
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            cmp = 3'b010;
            @(negedge clk);
            if (i < 19) chk("w20_early_done", 32'(done_b), 32'd0);
        end
        in_valid = 1'b0;
        chk("w20_done", 32'(done_b), 32'd1);
        exp_r = sb.pop_front();
        chk("w20_eq_sat", 32'(eq_b), 32'(exp_r.eq));
        chk("w20_maj", 32'(maj_b), 32'(exp_r.maj));
        chk("w20_gt_lt_err", 32'({gt_b, lt_b, err_b}), 32'({exp_r.gt, exp_r.lt, exp_r.err}));

`ifdef CMP_TALLY_ABORT_EN
        // Abort after two samples
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            cmp = 3'b100;
            @(negedge clk);
        end
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        chk("abort_cnts", 32'({gt_a, eq_a, lt_a, maj_a, err_a}), 32'd0);
        // Abort coincident with the completing sample
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            in_valid = 1'b1;
            cmp = 3'b001;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_last_done", 32'(done_a), 32'd0);
        chk("abort_last_busy", 32'(busy_a), 32'd0);
        chk("abort_last_cnts", 32'({gt_a, eq_a, lt_a}), 32'd0);
        @(negedge clk);
        chk("abort_last_no_late_done", 32'(done_a), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
